// File: rtl/ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_if
// Bundles every non-clock/reset signal of the ID/EX operand stage.
//   stall, flush               pipeline control into the stage
//   id_*                       decoded fields from the ID stage
//   mem_*, wb_*                forwarding sources from later stages
//   opA, opB, aluOutSel        ALU inputs produced by the stage
//   ex_*                       registered EX-stage fields for downstream use
// Modports:
//   master - the side driving ID/MEM/WB inputs and consuming EX outputs
//   slave  - the operand stage itself
// ---------------------------------------------------------------------------
interface ex_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int SEL_W   = 4,
  parameter int RADDR_W = 5
);
  logic               stall;
  logic               flush;

  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [RADDR_W-1:0] id_rs1_addr;
  logic [RADDR_W-1:0] id_rs2_addr;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic               id_opa_sel;
  logic               id_opb_sel;
  logic [SEL_W-1:0]   id_alu_sel;
  logic [RADDR_W-1:0] id_rd_addr;
  logic               id_reg_write;

  logic               mem_reg_write;
  logic [RADDR_W-1:0] mem_rd_addr;
  logic [XLEN-1:0]    mem_rd_data;
  logic               wb_reg_write;
  logic [RADDR_W-1:0] wb_rd_addr;
  logic [XLEN-1:0]    wb_rd_data;

  logic [XLEN-1:0]    opA;
  logic [XLEN-1:0]    opB;
  logic [SEL_W-1:0]   aluOutSel;
  logic               ex_valid;
  logic [RADDR_W-1:0] ex_rd_addr;
  logic               ex_reg_write;
  logic [XLEN-1:0]    ex_rs2_fwd;
  logic [XLEN-1:0]    ex_pc;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
    output id_imm, id_opa_sel, id_opb_sel, id_alu_sel, id_rd_addr, id_reg_write,
    output mem_reg_write, mem_rd_addr, mem_rd_data,
    output wb_reg_write, wb_rd_addr, wb_rd_data,
    input  opA, opB, aluOutSel, ex_valid, ex_rd_addr, ex_reg_write, ex_rs2_fwd, ex_pc
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
    input  id_imm, id_opa_sel, id_opb_sel, id_alu_sel, id_rd_addr, id_reg_write,
    input  mem_reg_write, mem_rd_addr, mem_rd_data,
    input  wb_reg_write, wb_rd_addr, wb_rd_data,
    output opA, opB, aluOutSel, ex_valid, ex_rd_addr, ex_reg_write, ex_rs2_fwd, ex_pc
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register with MEM/WB operand forwarding and ALU operand
// selection. Produces opA/opB/aluOutSel for the ALU that follows.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (overrides flush and stall)
//   bus  - ex_operand_stage_if.slave: stall/flush, id_* inputs, mem_*/wb_*
//          forwarding sources, opA/opB/aluOutSel and ex_* outputs
// Edge priority: rst > flush > stall > load.
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int SEL_W   = 4,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  ex_operand_stage_if.slave  bus
);

  // Fields captured from ID and held across stalls.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [SEL_W-1:0]   alu_sel;
    logic [RADDR_W-1:0] rd_addr;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic               opa_sel;
    logic               opb_sel;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
  } ex_ctrl_t;

  ex_ctrl_t        ctrl_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // MEM is the younger producer so it is checked first; x0 is never bypassed.
  function automatic logic [XLEN-1:0] forward(
    input logic [RADDR_W-1:0] src_addr,
    input logic [XLEN-1:0]    stored,
    input logic               mem_we,
    input logic [RADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]    mem_data,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]    wb_data
  );
    logic [XLEN-1:0] result;
    result = stored;
    if (src_addr != '0) begin
      if (mem_we && (mem_rd == src_addr)) begin
        result = mem_data;
      end else if (wb_we && (wb_rd == src_addr)) begin
        result = wb_data;
      end
    end
    return result;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rs1_fwd = forward(ctrl_q.rs1_addr, rs1_data_q,
                      bus.mem_reg_write, bus.mem_rd_addr, bus.mem_rd_data,
                      bus.wb_reg_write, bus.wb_rd_addr, bus.wb_rd_data);
    rs2_fwd = forward(ctrl_q.rs2_addr, rs2_data_q,
                      bus.mem_reg_write, bus.mem_rd_addr, bus.mem_rd_data,
                      bus.wb_reg_write, bus.wb_rd_addr, bus.wb_rd_data);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it is just the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (bus.flush) begin
      // Bubble: only the control that downstream acts on is cleared.
      ctrl_q.valid     <= 1'b0;
      ctrl_q.reg_write <= 1'b0;
      ctrl_q.alu_sel   <= '0;
    end else if (bus.stall) begin
      // Control holds; operand data absorbs any producer retiring now, so a
      // WB write seen only during the stall survives after it releases.
      rs1_data_q <= rs1_fwd;
      rs2_data_q <= rs2_fwd;
    end else begin
      ctrl_q.valid     <= bus.id_valid;
      ctrl_q.reg_write <= bus.id_reg_write & bus.id_valid;
      ctrl_q.alu_sel   <= bus.id_alu_sel;
      ctrl_q.rd_addr   <= bus.id_rd_addr;
      ctrl_q.rs1_addr  <= bus.id_rs1_addr;
      ctrl_q.rs2_addr  <= bus.id_rs2_addr;
      ctrl_q.opa_sel   <= bus.id_opa_sel;
      ctrl_q.opb_sel   <= bus.id_opb_sel;
      ctrl_q.pc        <= bus.id_pc;
      ctrl_q.imm       <= bus.id_imm;
      rs1_data_q       <= bus.id_rs1_data;
      rs2_data_q       <= bus.id_rs2_data;
    end
  end

  assign bus.opA          = ctrl_q.opa_sel ? ctrl_q.pc  : rs1_fwd;
  assign bus.opB          = ctrl_q.opb_sel ? ctrl_q.imm : rs2_fwd;
  assign bus.ex_rs2_fwd   = rs2_fwd;
  assign bus.aluOutSel    = ctrl_q.alu_sel;
  assign bus.ex_valid     = ctrl_q.valid;
  assign bus.ex_reg_write = ctrl_q.reg_write;
  assign bus.ex_rd_addr   = ctrl_q.rd_addr;
  assign bus.ex_pc        = ctrl_q.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed vector table, a hand-written stall-refresh sequence, and a
// randomized run against a record-level reference model of the EX stage.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(32), .SEL_W(4), .RADDR_W(5)) bus ();

  ex_operand_stage #(.XLEN(32), .SEL_W(4), .RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm;
    logic        opa_sel, opb_sel;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mem_w;
    logic [4:0]  mem_rd;
    logic [31:0] mem_d;
    logic        wb_w;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic        e_valid, e_rw;
    logic [3:0]  e_alu;
    logic        chk_data;
    logic [31:0] e_opa, e_opb, e_fwd, e_pc;
    logic [4:0]  e_rd;
  } vec_t;

  // Model of what the EX stage logically holds: the instruction record
  // plus operand values that have absorbed any producer seen during stalls.
  typedef struct {
    logic        valid, rw;
    logic [3:0]  alu;
    logic [4:0]  rd, rs1a, rs2a;
    logic        opa_sel, opb_sel;
    logic [31:0] pc, imm, rs1d, rs2d;
  } rec_t;

  int n_vec  = 0;
  int n_miss = 0;
  in_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t i);
    cur                = i;
    rst                = i.rst;
    bus.stall          = i.stall;
    bus.flush          = i.flush;
    bus.id_valid       = i.valid;
    bus.id_pc          = i.pc;
    bus.id_rs1_addr    = i.rs1a;
    bus.id_rs2_addr    = i.rs2a;
    bus.id_rs1_data    = i.rs1d;
    bus.id_rs2_data    = i.rs2d;
    bus.id_imm         = i.imm;
    bus.id_opa_sel     = i.opa_sel;
    bus.id_opb_sel     = i.opb_sel;
    bus.id_alu_sel     = i.alu;
    bus.id_rd_addr     = i.rd;
    bus.id_reg_write   = i.rw;
    bus.mem_reg_write  = i.mem_w;
    bus.mem_rd_addr    = i.mem_rd;
    bus.mem_rd_data    = i.mem_d;
    bus.wb_reg_write   = i.wb_w;
    bus.wb_rd_addr     = i.wb_rd;
    bus.wb_rd_data     = i.wb_d;
  endtask

  // Value a source register really has right now given in-flight producers.
  function automatic logic [31:0] live_value(input logic [4:0] a, input logic [31:0] held, input in_t i);
    if (a == 5'd0) return held;
    if (i.mem_w && i.mem_rd == a) return i.mem_d;
    if (i.wb_w && i.wb_rd == a) return i.wb_d;
    return held;
  endfunction

  function automatic rec_t next_rec(input rec_t r, input in_t i);
    rec_t n;
    n = r;
    if (i.rst) begin
      n = '{valid: 1'b0, rw: 1'b0, alu: 4'd0, rd: 5'd0, rs1a: 5'd0, rs2a: 5'd0,
            opa_sel: 1'b0, opb_sel: 1'b0, pc: 32'd0, imm: 32'd0, rs1d: 32'd0, rs2d: 32'd0};
    end else if (i.flush) begin
      n.valid = 1'b0;
      n.rw    = 1'b0;
      n.alu   = 4'd0;
    end else if (i.stall) begin
      n.rs1d = live_value(r.rs1a, r.rs1d, i);
      n.rs2d = live_value(r.rs2a, r.rs2d, i);
    end else begin
      n = '{valid: i.valid, rw: i.rw && i.valid, alu: i.alu, rd: i.rd, rs1a: i.rs1a,
            rs2a: i.rs2a, opa_sel: i.opa_sel, opb_sel: i.opb_sel, pc: i.pc,
            imm: i.imm, rs1d: i.rs1d, rs2d: i.rs2d};
    end
    return n;
  endfunction

  function automatic in_t base_in();
    in_t b;
    b = '{rst: 1'b0, stall: 1'b0, flush: 1'b0, valid: 1'b1, pc: 32'h40,
          rs1a: 5'd1, rs2a: 5'd2, rs1d: 32'd5, rs2d: 32'd1, imm: 32'd0,
          opa_sel: 1'b0, opb_sel: 1'b0, alu: 4'd0, rd: 5'd7, rw: 1'b1,
          mem_w: 1'b0, mem_rd: 5'd0, mem_d: 32'd0, wb_w: 1'b0, wb_rd: 5'd0, wb_d: 32'd0};
    return b;
  endfunction

  function automatic vec_t mk(input string name, input in_t i, input logic v, input logic rw,
                              input logic [3:0] alu, input logic chk,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] f,
                              input logic [31:0] pc, input logic [4:0] rd);
    vec_t t;
    t = '{name: name, in: i, e_valid: v, e_rw: rw, e_alu: alu, chk_data: chk,
          e_opa: a, e_opb: b, e_fwd: f, e_pc: pc, e_rd: rd};
    return t;
  endfunction

  vec_t tbl[$];
  rec_t model;

  initial begin
    in_t i;

    // ---------------- directed vector table ----------------
    i = base_in(); i.rst = 1'b1;
    tbl.push_back(mk("reset_1", i, 0, 0, 4'd0, 1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    tbl.push_back(mk("reset_2", i, 0, 0, 4'd0, 1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    i = base_in();
    tbl.push_back(mk("plain_load", i, 1, 1, 4'd0, 1, 32'd5, 32'd1, 32'd1, 32'h40, 5'd7));
    i = base_in(); i.opb_sel = 1'b1; i.imm = 32'hFFFF_FFFC; i.alu = 4'd3;
    tbl.push_back(mk("imm_opb", i, 1, 1, 4'd3, 1, 32'd5, 32'hFFFF_FFFC, 32'd1, 32'h40, 5'd7));
    i = base_in(); i.rs1a = 5'd3; i.rs1d = 32'd11;
    i.mem_w = 1'b1; i.mem_rd = 5'd3; i.mem_d = 32'd38;
    i.wb_w  = 1'b1; i.wb_rd  = 5'd3; i.wb_d  = 32'd7;
    tbl.push_back(mk("fwd_mem_wins", i, 1, 1, 4'd0, 1, 32'd38, 32'd1, 32'd1, 32'h40, 5'd7));
    i.mem_w = 1'b0;
    tbl.push_back(mk("fwd_wb", i, 1, 1, 4'd0, 1, 32'd7, 32'd1, 32'd1, 32'h40, 5'd7));
    i = base_in(); i.rs1a = 5'd0; i.rs1d = 32'd0;
    i.mem_w = 1'b1; i.mem_rd = 5'd0; i.mem_d = 32'd99;
    i.wb_w  = 1'b1; i.wb_rd  = 5'd0; i.wb_d  = 32'd55;
    tbl.push_back(mk("x0_no_fwd", i, 1, 1, 4'd0, 1, 32'd0, 32'd1, 32'd1, 32'h40, 5'd7));
    i = base_in(); i.opa_sel = 1'b1; i.pc = 32'h100; i.opb_sel = 1'b1; i.imm = 32'd4;
    tbl.push_back(mk("pc_operand", i, 1, 1, 4'd0, 1, 32'h100, 32'd4, 32'd1, 32'h100, 5'd7));
    i = base_in(); i.rs2a = 5'd6; i.rs2d = 32'd9; i.alu = 4'd5;
    i.wb_w = 1'b1; i.wb_rd = 5'd6; i.wb_d = 32'd21;
    tbl.push_back(mk("fwd_rs2", i, 1, 1, 4'd5, 1, 32'd5, 32'd21, 32'd21, 32'h40, 5'd7));
    i = base_in(); i.flush = 1'b1; i.stall = 1'b1; i.alu = 4'd9;
    tbl.push_back(mk("flush_over_stall", i, 0, 0, 4'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    i = base_in(); i.valid = 1'b0; i.rw = 1'b1;
    tbl.push_back(mk("rw_gated_by_valid", i, 0, 0, 4'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    i = base_in(); i.rw = 1'b0; i.alu = 4'd2;
    tbl.push_back(mk("load_no_write", i, 1, 0, 4'd2, 1, 32'd5, 32'd1, 32'd1, 32'h40, 5'd7));
    i = base_in(); i.stall = 1'b1; i.rd = 5'd9; i.alu = 4'd6; i.pc = 32'h80; i.rs1d = 32'd77;
    i.mem_w = 1'b1; i.mem_rd = 5'd1; i.mem_d = 32'hAB;
    tbl.push_back(mk("stall_hold_fwd", i, 1, 0, 4'd2, 1, 32'hAB, 32'd1, 32'd1, 32'h40, 5'd7));
    i.mem_w = 1'b0;
    tbl.push_back(mk("stall_refresh_kept", i, 1, 0, 4'd2, 1, 32'hAB, 32'd1, 32'd1, 32'h40, 5'd7));

    apply(base_in());
    foreach (tbl[k]) begin
      apply(tbl[k].in);
      @(posedge clk); #1;
      check({tbl[k].name, ".ex_valid"},     32'(bus.ex_valid),     32'(tbl[k].e_valid));
      check({tbl[k].name, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(tbl[k].e_rw));
      check({tbl[k].name, ".aluOutSel"},    32'(bus.aluOutSel),    32'(tbl[k].e_alu));
      if (tbl[k].chk_data) begin
        check({tbl[k].name, ".opA"},        bus.opA,               tbl[k].e_opa);
        check({tbl[k].name, ".opB"},        bus.opB,               tbl[k].e_opb);
        check({tbl[k].name, ".ex_rs2_fwd"}, bus.ex_rs2_fwd,        tbl[k].e_fwd);
        check({tbl[k].name, ".ex_pc"},      bus.ex_pc,             tbl[k].e_pc);
        check({tbl[k].name, ".ex_rd_addr"}, 32'(bus.ex_rd_addr),   32'(tbl[k].e_rd));
      end
    end

    // ---------------- stall refresh across a WB retirement ----------------
    i = base_in(); i.rs2a = 5'd4; i.rs2d = 32'd0; i.alu = 4'd1;
    i.wb_w = 1'b1; i.wb_rd = 5'd4; i.wb_d = 32'd33;
    apply(i);
    @(posedge clk); #1;
    check("stall_seq.capture.opB", bus.opB, 32'd33);
    i.stall = 1'b1; i.alu = 4'd8;
    apply(i);
    @(posedge clk); #1;
    check("stall_seq.cyc1.opB", bus.opB, 32'd33);
    i.wb_w = 1'b0;
    apply(i);
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall_seq.cyc%0d.opB", c), bus.opB, 32'd33);
      check($sformatf("stall_seq.cyc%0d.aluOutSel", c), 32'(bus.aluOutSel), 32'd1);
    end
    i.stall = 1'b0; i.rs2d = 32'd33; i.alu = 4'd8;
    apply(i);
    @(posedge clk); #1;
    check("stall_seq.release.opB", bus.opB, 32'd33);
    check("stall_seq.release.aluOutSel", 32'(bus.aluOutSel), 32'd8);

    // ---------------- randomized run against the record model ----------------
    i = base_in(); i.rst = 1'b1;
    apply(i);
    @(posedge clk);
    model = next_rec(model, cur);
    #1;
    for (int n = 0; n < 1500; n++) begin
      i.rst     = ($urandom_range(0, 49) == 0);
      i.flush   = ($urandom_range(0, 9) == 0);
      i.stall   = ($urandom_range(0, 4) == 0);
      i.valid   = $urandom_range(0, 3) != 0;
      i.pc      = $urandom;
      i.rs1a    = 5'($urandom_range(0, 3));
      i.rs2a    = 5'($urandom_range(0, 3));
      i.rs1d    = (i.rs1a == 5'd0) ? 32'd0 : $urandom;
      i.rs2d    = (i.rs2a == 5'd0) ? 32'd0 : $urandom;
      i.imm     = $urandom;
      i.opa_sel = 1'($urandom);
      i.opb_sel = 1'($urandom);
      i.alu     = 4'($urandom);
      i.rd      = 5'($urandom);
      i.rw      = 1'($urandom);
      i.mem_w   = 1'($urandom);
      i.mem_rd  = 5'($urandom_range(0, 3));
      i.mem_d   = $urandom;
      i.wb_w    = 1'($urandom);
      i.wb_rd   = 5'($urandom_range(0, 3));
      i.wb_d    = $urandom;
      apply(i);
      @(posedge clk);
      model = next_rec(model, cur);
      #1;
      check("rand.ex_valid",     32'(bus.ex_valid),     32'(model.valid));
      check("rand.ex_reg_write", 32'(bus.ex_reg_write), 32'(model.rw));
      check("rand.aluOutSel",    32'(bus.aluOutSel),    32'(model.alu));
      if (model.valid) begin
        check("rand.opA", bus.opA,
              model.opa_sel ? model.pc : live_value(model.rs1a, model.rs1d, cur));
        check("rand.opB", bus.opB,
              model.opb_sel ? model.imm : live_value(model.rs2a, model.rs2d, cur));
        check("rand.ex_rs2_fwd", bus.ex_rs2_fwd, live_value(model.rs2a, model.rs2d, cur));
        check("rand.ex_pc",      bus.ex_pc,      model.pc);
        check("rand.ex_rd_addr", 32'(bus.ex_rd_addr), 32'(model.rd));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and operand-select logic.
- Sits directly upstream of the ALU and produces its `opA`, `opB` and `aluOutSel` inputs.
- Latches decoded instruction fields each cycle and resolves RAW hazards by forwarding from the MEM and WB stages.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
XLEN, 32, datapath width
SEL_W, 4, ALU operation-select width
RADDR_W, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  hold current EX contents
flush  in  1  replace EX contents with a bubble
id_valid  in  1  decode stage holds a valid instruction
id_pc  in  XLEN  instruction PC
id_rs1_addr  in  RADDR_W  source register 1 index
id_rs2_addr  in  RADDR_W  source register 2 index
id_rs1_data  in  XLEN  register-file read data 1
id_rs2_data  in  XLEN  register-file read data 2
id_imm  in  XLEN  sign-extended immediate
id_opa_sel  in  1  0 = rs1, 1 = pc
id_opb_sel  in  1  0 = rs2, 1 = imm
id_alu_sel  in  SEL_W  ALU operation code
id_rd_addr  in  RADDR_W  destination register
id_reg_write  in  1  instruction writes rd
mem_reg_write  in  1  MEM stage will write mem_rd_addr
mem_rd_addr  in  RADDR_W  MEM destination register
mem_rd_data  in  XLEN  MEM result
wb_reg_write  in  1  WB stage writing wb_rd_addr
wb_rd_addr  in  RADDR_W  WB destination register
wb_rd_data  in  XLEN  WB result
opA  out  XLEN  ALU operand A (combinational from stage registers)
opB  out  XLEN  ALU operand B (combinational from stage registers)
aluOutSel  out  SEL_W  ALU operation select (registered)
ex_valid  out  1  EX stage holds a valid instruction
ex_rd_addr  out  RADDR_W  registered rd
ex_reg_write  out  1  registered write enable, gated by ex_valid
ex_rs2_fwd  out  XLEN  forwarded rs2 value (store data)
ex_pc  out  XLEN  registered PC

Behaviour:
Reset:
- On rising edge with `rst` = 1, all stage registers clear to 0: `ex_valid` = 0, `ex_reg_write` = 0, `aluOutSel` = 0000, `ex_rd_addr` = 0, `ex_pc` = 0.
- Outputs therefore settle to `opA` = `opB` = `ex_rs2_fwd` = 0.
- `rst` overrides `flush` and `stall`.

Update priority per edge: `rst` > `flush` > `stall` > load.
- Load: all `id_*` fields are captured; `ex_valid` <= `id_valid`.
- Flush: `ex_valid` = 0, `ex_reg_write` = 0, `aluOutSel` = 0000. Data registers may hold any value; outputs are don't-care except `ex_reg_write` = 0.
- Stall: all control fields are held. Stored rs1/rs2 data are refreshed with their current forwarded values (see below), so a producer retiring from WB during the stall is not lost.
- Latency: an ID field appears on the EX outputs 1 cycle after capture.

Forwarding (combinational, per source s in {rs1, rs2}):
- Priority 1: if `mem_reg_write` and `mem_rd_addr` == s_addr and s_addr != 0, use `mem_rd_data`.
- Priority 2: otherwise, if `wb_reg_write` and `wb_rd_addr` == s_addr and s_addr != 0, use `wb_rd_data`.
- Otherwise use the stored register-file data.
- Register x0 is never forwarded; it always reads the stored value, which is 0 from the regfile.
- MEM and WB matching simultaneously: MEM wins, since it is the younger producer.

Operand select:
- `opA` = `ex_pc` if the stored opa_sel = 1, else the forwarded rs1.
- `opB` = stored imm if the stored opb_sel = 1, else the forwarded rs2.
- `ex_rs2_fwd` is always the forwarded rs2, independent of opb_sel.

Other rules:
- `ex_reg_write` is registered as `id_reg_write` & `id_valid`.
- No arithmetic is performed in this block. Widths pass through unchanged; no sign or zero extension is done here.
- `stall` and `flush` asserted together: flush wins.
- `stall` while `ex_valid` = 0: registers hold; forwarding refresh is harmless.

Test Plan:
- Reset: assert `rst` for 2 cycles with `id_valid` = 1 -> `ex_valid` = 0, `aluOutSel` = 0000, `opA` = `opB` = 0. One cycle after `rst` drops, captured fields appear.
- Plain load: rs1_data = 5, rs2_data = 1, sel = 0/0, alu_sel = 0000, no forwarding matches -> next cycle `opA` = 5, `opB` = 1, `aluOutSel` = 0000. Then opb_sel = 1, imm = 0xFFFFFFFC -> `opB` = 0xFFFFFFFC.
- Forward priority: rs1_addr = 3 with mem (rd = 3, data = 38) and wb (rd = 3, data = 7) both writing -> `opA` = 38. Deassert mem_reg_write -> `opA` = 7. Set rs1_addr = 0 with mem rd = 0, data = 99 -> `opA` = stored 0.
- Stall refresh: capture rs2_addr = 4, rs2_data = 0 while wb writes rd 4 = 33; hold `stall` = 1 for 3 cycles and drop wb_reg_write after cycle 1 -> `opB` stays 33 throughout and after the stall releases.
- Flush vs stall: `ex_valid` = 1, `ex_reg_write` = 1, then `flush` = 1 and `stall` = 1 in the same cycle -> next cycle `ex_valid` = 0, `ex_reg_write` = 0, `aluOutSel` = 0000.
- PC operand: opa_sel = 1, pc = 0x100, opb_sel = 1, imm = 4, alu_sel = 0000 -> `opA` = 0x100, `opB` = 4, `ex_pc` = 0x100.
